vga_timing_gen: RTL

//  Produces the pixel coordinates (x, y) and the VGA sync/blank strobes.
//  The pixel generator consumes (x, y) and returns r/g/b for each pixel.

---
 rtl/vga_timing_gen.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing.
// Divides the system clock down to the pixel rate, walks the (x, y) raster
// over the full line/frame including porches and sync, and produces
// registered sync/blank strobes that decode the current (x, y) with zero skew,
// plus one-clock line/frame start pulses.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned HACTIVE = 640,
  parameter int unsigned HFP     = 16,
  parameter int unsigned HSYNC   = 96,
  parameter int unsigned HBP     = 48,
  parameter int unsigned VACTIVE = 480,
  parameter int unsigned VFP     = 10,
  parameter int unsigned VSYNC   = 2,
  parameter int unsigned VBP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       pix_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       blank_n,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned HTOTAL = HACTIVE + HFP + HSYNC + HBP;
  localparam int unsigned VTOTAL = VACTIVE + VFP + VSYNC + VBP;

  // A divide-by-one still keeps a 1-bit divider that never leaves zero.
  localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  // Raster limits; counters compare against the last index, never overflow.
  localparam logic [9:0] H_LAST   = 10'(HTOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(VTOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(HACTIVE);
  localparam logic [9:0] V_VIS    = 10'(VACTIVE);
  localparam logic [9:0] HS_BEGIN = 10'(HACTIVE + HFP);
  localparam logic [9:0] HS_END   = 10'(HACTIVE + HFP + HSYNC);
  localparam logic [9:0] VS_BEGIN = 10'(VACTIVE + VFP);
  localparam logic [9:0] VS_END   = 10'(VACTIVE + VFP + VSYNC);

  // Horizontal sync window: HS_BEGIN <= x < HS_END.
  function automatic logic in_hsync(input logic [9:0] xv);
    return (xv >= HS_BEGIN) && (xv < HS_END);
  endfunction

  // Vertical sync window, whole lines: VS_BEGIN <= y < VS_END.
  function automatic logic in_vsync(input logic [9:0] yv);
    return (yv >= VS_BEGIN) && (yv < VS_END);
  endfunction

  // Visible area test.
  function automatic logic is_visible(input logic [9:0] xv, input logic [9:0] yv);
    return (xv < H_VIS) && (yv < V_VIS);
  endfunction

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic [9:0]       x_q;
  logic [9:0]       x_d;
  logic [9:0]       y_q;
  logic [9:0]       y_d;
  logic             hsync_n_q;
  logic             hsync_n_d;
  logic             vsync_n_q;
  logic             vsync_n_d;
  logic             blank_n_q;
  logic             blank_n_d;
  logic             line_start_q;
  logic             line_start_d;
  logic             frame_start_q;
  logic             frame_start_d;
  logic             pix_tick_s;

  // Pixel strobe is combinational so the counters step on the same edge.
  assign pix_tick_s = en && (div_q == DIV_LAST);

  // Pixel-rate divider: wraps at CLK_DIV-1 and freezes while en is low.
  always_comb begin
    div_d = div_q;
    if (!en) begin
      div_d = div_q;
    end else if (div_q == DIV_LAST) begin
      div_d = {DIV_W{1'b0}};
    end else begin
      div_d = div_q + DIV_ONE;
    end
  end

  // Raster counters: x steps every pixel, y steps when x wraps.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (pix_tick_s) begin
      if (x_q == H_LAST) begin
        x_d = 10'd0;
        if (y_q == V_LAST) begin
          y_d = 10'd0;
        end else begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
        y_d = y_q;
      end
    end else begin
      x_d = x_q;
      y_d = y_q;
    end
  end

  // Strobes decode the next (x, y) so they line up with the counters; pulses last one clk.
  always_comb begin
    hsync_n_d     = hsync_n_q;
    vsync_n_d     = vsync_n_q;
    blank_n_d     = blank_n_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (pix_tick_s) begin
      hsync_n_d     = ~in_hsync(x_d);
      vsync_n_d     = ~in_vsync(y_d);
      blank_n_d     = is_visible(x_d, y_d);
      line_start_d  = (x_d == 10'd0);
      frame_start_d = (x_d == 10'd0) && (y_d == 10'd0);
    end else begin
      hsync_n_d     = hsync_n_q;
      vsync_n_d     = vsync_n_q;
      blank_n_d     = blank_n_q;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
    end
  end

  // Divider and counter state; reset parks the raster on its final pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= {DIV_W{1'b0}};
      x_q   <= H_LAST;
      y_q   <= V_LAST;
    end else begin
      div_q <= div_d;
      x_q   <= x_d;
      y_q   <= y_d;
    end
  end

  // Registered sync/blank strobes and start pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_n_q     <= 1'b1;
      vsync_n_q     <= 1'b1;
      blank_n_q     <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_n_q     <= hsync_n_d;
      vsync_n_q     <= vsync_n_d;
      blank_n_q     <= blank_n_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pix_tick    = pix_tick_s;
  assign x           = x_q;
  assign y           = y_q;
  assign hsync_n     = hsync_n_q;
  assign vsync_n     = vsync_n_q;
  assign blank_n     = blank_n_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule
